// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^M) digit-serial multiplier.
//   M_DEFAULT  : default field degree (NIST B-163)
//   POLY_B163  : low terms of x^163 + x^7 + x^6 + x^3 + 1
//   POLY_AES8  : low terms of x^8 + x^4 + x^3 + x + 1
//   state_t    : controller states
//   ceil_div() : integer ceiling division, used to size the digit count
package gf2m_pkg;

    localparam int           M_DEFAULT = 163;
    localparam logic [162:0] POLY_B163 = 163'hC9;
    localparam logic [7:0]   POLY_AES8 = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/gf2m_xtime_d.sv
// Combinational multiply by x^D modulo f(x) = x^M + POLY.
// Performs D successive single-bit xtime folds: shift left by one and, if
// the bit shifted out was set, XOR in POLY. Works for any POLY of degree < M.
//   din  : input  [M-1:0]  field element
//   dout : output [M-1:0]  din * x^D mod f
module gf2m_xtime_d
    import gf2m_pkg::*;
#(
    parameter int         M    = M_DEFAULT,
    parameter int         D    = 1,
    parameter logic [M-1:0] POLY = M'(POLY_B163)
) (
    input  logic [M-1:0] din,
    output logic [M-1:0] dout
);

    logic [M-1:0] v;

    always_comb begin
        // NOTE: v is assigned before the loop so every path writes it (no latch);
        // blocking '=' is correct here because each fold consumes the previous one.
        v = din;
        for (int i = 0; i < D; i++) begin
            v = (v << 1) ^ (v[M-1] ? POLY : '0);
        end
        dout = v;
    end

endmodule

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier, c = a*b mod f(x).
// b is consumed D bits per cycle, most significant digit first, using
// Horner's rule: acc = acc*x^D ^ a*digit (both reduced mod f).
// Result appears N = ceil(M/D) cycles after the accept edge.
//   clk, rst           : clock (rising edge), async active-low reset
//   in_valid/in_ready  : operand handshake (a, b)
//   abort              : synchronous cancel, returns to IDLE, no result
//   c, out_valid       : product and its valid flag (held until out_ready)
//   out_ready          : consumer accepts the result
//   busy               : operation in progress or result pending
module gf2m_digit_mult
    import gf2m_pkg::*;
#(
    parameter int           M    = M_DEFAULT,
    parameter int           D    = 4,
    parameter logic [M-1:0] POLY = M'(POLY_B163)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         abort,
    output logic [M-1:0] c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int N  = ceil_div(M, D);
    localparam int PW = N * D;                      // b padded to whole digits
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state, state_nx;
    logic [M-1:0]   a_reg;
    logic [PW-1:0]  b_reg;
    logic [M-1:0]   acc;
    logic [M-1:0]   acc_shift;
    logic [M-1:0]   prod;
    logic [M-1:0]   acc_nx;
    logic [CW-1:0]  cnt;
    logic [D-1:0]   digit;
    logic           accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready && !abort;
    assign digit     = b_reg[PW-1 -: D];

    // acc * x^D mod f
    gf2m_xtime_d #(.M(M), .D(D), .POLY(POLY)) u_acc_xtime (
        .din  (acc),
        .dout (acc_shift)
    );

    // a * digit mod f, Horner over the digit bits (MSB first) with one
    // single-bit fold per bit.
    for (genvar g = 0; g < D; g++) begin : g_fold
        logic [M-1:0] t_in, t_sh, t_out;
        if (g == 0) begin : g_first
            assign t_in = '0;
        end else begin : g_rest
            assign t_in = g_fold[g-1].t_out;
        end
        gf2m_xtime_d #(.M(M), .D(1), .POLY(POLY)) u_bit_xtime (
            .din  (t_in),
            .dout (t_sh)
        );
        assign t_out = t_sh ^ (digit[D-1-g] ? a_reg : '0);
    end

    assign prod   = g_fold[D-1].t_out;
    assign acc_nx = acc_shift ^ prod;

    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept)                 state_nx = CALC;
            CALC: if (abort)                  state_nx = IDLE;
                  else if (cnt == '0)         state_nx = DONE;
            DONE: if (abort || out_ready)     state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            c     <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= PW'(b);
            acc   <= '0;
            cnt   <= CW'(N - 1);
        end else if (state == CALC) begin
            if (abort) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc   <= acc_nx;
                b_reg <= b_reg << D;
                cnt   <= cnt - 1'b1;
                // c only changes on entry to DONE, so it is stable there
                if (cnt == '0) c <= acc_nx;
            end
        end
    end

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Self-checking bench for gf2m_digit_mult. Three instances:
//   k=0 : M=163, D=4, B-163 polynomial  (N=41)
//   k=1 : M=8,   D=3, AES polynomial    (N=3)
//   k=2 : M=8,   D=8, AES polynomial    (N=1)
// Expected products come from a schoolbook carry-less multiply followed by
// long-division reduction by f(x).
module tb_gf2m_digit_mult;
    import gf2m_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid_v, abort_v, out_ready_v;
    wire  [2:0]   in_ready_v, out_valid_v, busy_v;
    logic [162:0] a_s [3];
    logic [162:0] b_s [3];
    wire  [162:0] c0;
    wire  [7:0]   c1, c2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf2m_digit_mult #(.M(163), .D(4), .POLY(POLY_B163)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_s[0]), .b(b_s[0]), .abort(abort_v[0]), .c(c0),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .busy(busy_v[0]));

    gf2m_digit_mult #(.M(8), .D(3), .POLY(POLY_AES8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .abort(abort_v[1]), .c(c1),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .busy(busy_v[1]));

    gf2m_digit_mult #(.M(8), .D(8), .POLY(POLY_AES8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_s[2][7:0]), .b(b_s[2][7:0]), .abort(abort_v[2]), .c(c2),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .busy(busy_v[2]));

    function automatic int m_of(input int k);
        return (k == 0) ? 163 : 8;
    endfunction

    function automatic int n_of(input int k);
        int d;
        d = (k == 0) ? 4 : (k == 1) ? 3 : 8;
        return (m_of(k) + d - 1) / d;
    endfunction

    function automatic logic [162:0] poly_of(input int k);
        return (k == 0) ? POLY_B163 : 163'(POLY_AES8);
    endfunction

    function automatic logic [162:0] c_of(input int k);
        return (k == 0) ? c0 : (k == 1) ? 163'(c1) : 163'(c2);
    endfunction

    function automatic logic [162:0] mask_of(input int k);
        logic [162:0] one;
        one = 163'd1;
        return (m_of(k) >= 163) ? '1 : ((one << m_of(k)) - 163'd1);
    endfunction

    // Reference: full carry-less product, then reduce from the top bit down.
    function automatic logic [162:0] ref_mul(input logic [162:0] x, y, input int k);
        logic [325:0] p;
        logic [325:0] f;
        int m;
        m = m_of(k);
        p = '0;
        for (int i = 0; i < m; i++)
            if (y[i]) p = p ^ (326'(x) << i);
        f = (326'(1) << m) | 326'(poly_of(k));
        for (int i = 2 * m - 2; i >= m; i--)
            if (p[i]) p = p ^ (f << (i - m));
        return p[162:0] & mask_of(k);
    endfunction

    function automatic logic [162:0] rand_op(input int k);
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[162:0] & mask_of(k);
    endfunction

    task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, measure latency, check result, release.
    task automatic do_op(input int k, input logic [162:0] x, y, input string tag,
                         output logic [162:0] res);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 163'(in_ready_v[k]), 163'd1);
        a_s[k] = x; b_s[k] = y; in_valid_v[k] = 1'b1;
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        lat = 0;
        while (!out_valid_v[k] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 163'(lat), 163'(n_of(k)));
        res = c_of(k);
        check({tag, "_c"}, res, ref_mul(x, y, k));
        out_ready_v[k] = 1'b1;
        @(negedge clk);
        out_ready_v[k] = 1'b0;
        check({tag, "_released"}, 163'(out_valid_v[k]), 163'd0);
    endtask

    initial begin
        logic [162:0] res, held, x, y;
        bit           ov_seen;
        int           lat;

        in_valid_v = '0; abort_v = '0; out_ready_v = '0;
        for (int k = 0; k < 3; k++) begin a_s[k] = '0; b_s[k] = '0; end
        rst = 1'b0;
        #12;
        for (int k = 0; k < 3; k++) begin
            check("rst_c", c_of(k), '0);
            check("rst_out_valid", 163'(out_valid_v[k]), 163'd0);
            check("rst_busy", 163'(busy_v[k]), 163'd0);
            check("rst_in_ready", 163'(in_ready_v[k]), 163'd1);
        end
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors
        do_op(0, 163'd1, 163'd1, "one_x_one", res);
        check("one_x_one_const", res, 163'd1);
        x = 163'd1 << 162;
        do_op(0, x, 163'd2, "x163_reduce", res);
        check("x163_reduce_const", res, 163'hC9);
        do_op(1, 163'h57, 163'h83, "aes_57_83", res);
        check("aes_57_83_const", res, 163'hC1);
        do_op(2, 163'h57, 163'h83, "aes_full_digit", res);
        check("aes_full_digit_const", res, 163'hC1);

        // Random and zero-operand transactions on every instance
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) do_op(k, rand_op(k), rand_op(k), "random", res);
            do_op(k, '0, rand_op(k), "zero_a", res);
            check("zero_a_const", res, '0);
            do_op(k, rand_op(k), '0, "zero_b", res);
            check("zero_b_const", res, '0);
        end

        // Backpressure: result held for 5 cycles with out_ready low
        x = rand_op(0); y = rand_op(0);
        @(negedge clk);
        a_s[0] = x; b_s[0] = y; in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (!out_valid_v[0] && lat < 400) begin @(negedge clk); lat++; end
        check("bp_latency", 163'(lat), 163'd41);
        held = c0;
        check("bp_c", held, ref_mul(x, y, 0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 163'(out_valid_v[0]), 163'd1);
            check("bp_c_stable", c0, held);
            check("bp_in_ready", 163'(in_ready_v[0]), 163'd0);
        end
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        check("bp_released", 163'(out_valid_v[0]), 163'd0);
        check("bp_idle", 163'(in_ready_v[0]), 163'd1);

        // Abort at CALC cycle 10, then a fresh operation
        @(negedge clk);
        a_s[0] = rand_op(0); b_s[0] = rand_op(0); in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check("abort_busy", 163'(busy_v[0]), 163'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ov_seen |= out_valid_v[0];
        end
        check("abort_no_out_valid", 163'(ov_seen), 163'd0);
        do_op(0, 163'd3, 163'd3, "after_abort", res);
        check("after_abort_const", res, 163'd5);

        // Abort wins over in_valid in IDLE
        @(negedge clk);
        a_s[1] = 163'h12; b_s[1] = 163'h34; in_valid_v[1] = 1'b1; abort_v[1] = 1'b1;
        @(negedge clk);
        in_valid_v[1] = 1'b0; abort_v[1] = 1'b0;
        check("abort_idle_busy", 163'(busy_v[1]), 163'd0);
        check("abort_idle_in_ready", 163'(in_ready_v[1]), 163'd1);

        // Abort together with out_ready in DONE
        @(negedge clk);
        a_s[1] = 163'h12; b_s[1] = 163'h34; in_valid_v[1] = 1'b1;
        @(negedge clk);
        in_valid_v[1] = 1'b0;
        lat = 0;
        while (!out_valid_v[1] && lat < 50) begin @(negedge clk); lat++; end
        check("abort_done_latency", 163'(lat), 163'd3);
        abort_v[1] = 1'b1; out_ready_v[1] = 1'b1;
        @(negedge clk);
        abort_v[1] = 1'b0; out_ready_v[1] = 1'b0;
        check("abort_done_out_valid", 163'(out_valid_v[1]), 163'd0);
        check("abort_done_busy", 163'(busy_v[1]), 163'd0);

        // Reset pulsed mid-CALC
        @(negedge clk);
        a_s[0] = rand_op(0); b_s[0] = rand_op(0); in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", 163'(out_valid_v[0]), 163'd0);
        check("midrst_busy", 163'(busy_v[0]), 163'd0);
        check("midrst_c", c0, '0);
        check("midrst_in_ready", 163'(in_ready_v[0]), 163'd1);
        @(negedge clk);
        rst = 1'b1;
        do_op(0, 163'd2, 163'd2, "after_rst", res);
        check("after_rst_const", res, 163'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf2m_digit_mult.md
GF2M_DIGIT_MULT -- requirements
Module: gf2m_digit_mult

Interface
REQ-001 SHALL have parameter M, default 163, field degree of GF(2^M).
REQ-002 SHALL have parameter D, default 4, digit size in bits processed per cycle, legal range 1..M.
REQ-003 SHALL have parameter POLY, M bits, default 163'hC9, low terms of f(x) = x^M + POLY (NIST B-163: x^163+x^7+x^6+x^3+1).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operands a, b presented.
REQ-007 SHALL have port in_ready  output  1  block accepts operands.
REQ-008 SHALL have port a  input  M  multiplicand, polynomial basis.
REQ-009 SHALL have port b  input  M  multiplier, polynomial basis.
REQ-010 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-011 SHALL have port c  output  M  product a*b mod f.
REQ-012 SHALL have port out_valid  output  1  c holds a valid result.
REQ-013 SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL define N = ceil(M/D); b SHALL be zero-extended at the MSB end to N*D bits.
REQ-017 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-018 SHALL accept operands on in_valid&&in_ready: latch a and padded b, clear acc, set cnt=N-1, go to CALC.
REQ-019 SHALL, each CALC cycle, update acc = (acc*x^D mod f) XOR (a*bdigit mod f), MSB digit first, then shift b left by D.
REQ-020 SHALL compute both terms by D successive single-bit xtime folds using POLY, with no constraint on the degree of POLY.
REQ-021 SHALL go from CALC to DONE on the cycle cnt==0 completes; out_valid therefore rises exactly N cycles after the accept edge.
REQ-022 SHALL hold c stable in DONE until out_valid&&out_ready, then return to IDLE; a new accept is possible on the following cycle.
REQ-023 SHALL keep c at its last value outside DONE (not required to be valid).
REQ-024 SHALL return to IDLE on the next edge when abort=1 in any state, discarding acc, with no out_valid pulse.
REQ-025 SHALL give abort priority when abort and in_valid occur together in IDLE (no accept), and when abort and out_ready occur together in DONE (result dropped; same end state).
REQ-026 SHALL produce a zero result when a=0 or b=0; for D=M, N=1 and latency is 1 cycle.

Reset
REQ-027 SHALL, on rst low, immediately force state=IDLE, acc=0, c=0, cnt=0, out_valid=0, busy=0, and in_ready=1 once rst is high, regardless of the current operation.
REQ-028 SHALL leave no partial result visible after reset mid-CALC or mid-DONE.

Structure
REQ-029 SHALL take the default M, POLY_B163 (163'hC9), POLY_AES8 (8'h1B), the state enum and a ceil-div function from shared package gf2m_pkg.
REQ-030 SHALL place the combinational multiply-by-x^D-mod-f in sub-module gf2m_xtime_d (parameters M, D, POLY), instantiated for the acc term; the a*bdigit term reuses the single-bit xtime fold.

Verification
REQ-031 SHALL be checked with M=163, D=4, a=1, b=1: out_valid rises 41 cycles after accept, c=1.
REQ-032 SHALL be checked with M=163, D=4, a=1<<162, b=2: c=163'hC9 (x^163 reduced).
REQ-033 SHALL be checked with M=8, D=3, POLY=8'h1B, a=8'h57, b=8'h83: c=8'hC1 after 3 cycles.
REQ-034 SHALL be checked under backpressure: out_ready low for 5 cycles in DONE keeps c and out_valid stable and in_ready=0; the result is released on the first out_ready high.
REQ-035 SHALL be checked with abort at CALC cycle 10, then a new a=3, b=3 (M=163): no out_valid for the aborted operation; second result c=5.
REQ-036 SHALL be checked with rst pulsed low mid-CALC: outputs are immediately at reset values, and the next operation a=2, b=2 gives c=4.
